if_prefetch_unit: RTL

//  Instruction-fetch front end for the 5-stage ARMv8 pipeline. Owns the fetch PC.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_fifo.sv | 69 ++++++
 rtl/if_prefetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction prefetch unit
// Purpose: fetch FSM state encoding, PC increment and word-alignment mask.
// Ports: none (package).
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } ifu_state_t;

  // Fetch addresses advance one 32-bit instruction at a time.
  localparam int PC_STEP = 4;

  // Low PC bits that are forced to zero so every fetch is word aligned.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - prefetch queue holding {PC, instruction} entries
// Purpose: DEPTH-entry circular queue with push/pop/flush and occupancy count.
// Ports:
//   Clk, Rst       clock, asynchronous active-low reset
//   push/push_data write one entry (ignored when full or flushing)
//   pop            drop the head entry (ignored when empty or flushing)
//   flush          discard every entry
//   head_data      entry at the read pointer
//   count          number of valid entries (0..DEPTH)
//   full, empty    occupancy flags
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: consumers only look at it while count is non-zero.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction-fetch front end with prefetch queue
// Purpose: owns the fetch PC, issues one-outstanding req/ack fetches, buffers
//   {PC, instruction} pairs and hands them to IF/ID with valid/ready; MEM-stage
//   redirects flush the queue and restart fetch at the branch target.
// Optional feature macro: IFU_PERF_CNT_EN adds FetchCount/FlushCount outputs.
// Ports:
//   Clk, Rst               clock, asynchronous active-low reset
//   StartPC                PC loaded while in reset
//   ImemReq/ImemAddr       fetch request and word-aligned address
//   ImemAck/ImemData       response strobe and returned instruction
//   InstValid/Instruction/InstPC  queue head toward IF/ID
//   DecReady               IF/ID accepts the head this cycle
//   Redirect/RedirectPC    taken branch and its target
//   FetchCount/FlushCount  accepted pushes / redirects (IFU_PERF_CNT_EN only)
module if_prefetch_unit
  import ifu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] StartPC,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [INST_W-1:0] ImemData,
  output logic              InstValid,
  output logic [INST_W-1:0] Instruction,
  output logic [ADDR_W-1:0] InstPC,
  input  logic              DecReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       FlushCount
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INST_W;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(ALIGN_MASK);
  endfunction

  ifu_state_t         state;
  logic [ADDR_W-1:0]  fetch_pc;

  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   cnt_after_push;

  // A redirect kills both the response arriving this cycle and any pop.
  assign fifo_push = (state == REQ) && ImemAck && !Redirect;
  assign fifo_pop  = InstValid && DecReady && !Redirect;

  // Occupancy once this ack lands; the next request is only kept open if its
  // response is guaranteed a free slot.
  assign cnt_after_push = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (fifo_push),
    .push_data ({ImemAddr, ImemData}),
    .pop       (fifo_pop),
    .flush     (Redirect),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields are forced to zero while empty so reset/flush present clean zeros.
  assign InstValid   = !fifo_empty;
  assign Instruction = fifo_empty ? '0 : fifo_head[INST_W-1:0];
  assign InstPC      = fifo_empty ? '0 : fifo_head[ENTRY_W-1:INST_W];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      fetch_pc <= align_pc(StartPC);
      ImemReq  <= 1'b0;
      ImemAddr <= '0;
    end else begin
      if (Redirect) fetch_pc <= align_pc(RedirectPC);
      case (state)
        IDLE: begin
          // Nothing is outstanding here, so a non-full queue has room for one more.
          if (!Redirect && !fifo_full) begin
            ImemReq  <= 1'b1;
            ImemAddr <= fetch_pc;
            state    <= REQ;
          end
        end
        REQ: begin
          if (Redirect) begin
            if (ImemAck) begin
              ImemReq <= 1'b0;
              state   <= IDLE;
            end else begin
              // Bus forbids withdrawing a request: keep it up and discard its data.
              state <= DROP;
            end
          end else if (ImemAck) begin
            fetch_pc <= ImemAddr + ADDR_W'(PC_STEP);
            if (cnt_after_push < CNT_W'(DEPTH)) begin
              ImemAddr <= ImemAddr + ADDR_W'(PC_STEP);
            end else begin
              ImemReq <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          // The stale request still completes on ack even if another redirect
          // arrives, otherwise the FSM would wait for an ack that already came.
          if (ImemAck) begin
            ImemReq <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ImemReq <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      FetchCount <= '0;
      FlushCount <= '0;
    end else begin
      if (fifo_push) FetchCount <= FetchCount + 32'd1;
      if (Redirect)  FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule
